// File: rtl/ycc_ctrl_pkg.sv
// Shared constants, FSM state encoding and the output clamp for the YCbCr->RGB block controller.
package ycc_ctrl_pkg;

    localparam int unsigned FRAC_W  = 16;
    localparam int unsigned BLK_PIX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // v is the already floored (shifted) channel value; clamp it to an unsigned byte.
    function automatic logic [7:0] sat_u8(input logic signed [32:0] v);
        if (v[32]) begin
            return 8'd0;
        end
        if (|v[31:8]) begin
            return 8'hff;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/ycc_rgb_conv_ctrl_if.sv
// Bundles the block handshake, buffer read, converter and pixel stream signals of the controller.
interface ycc_rgb_conv_ctrl_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              blk_valid;
    logic              blk_ready;
    logic              blk_done;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [7:0]        buf_y;
    logic [7:0]        buf_cb;
    logic [7:0]        buf_cr;
    logic [31:0]       conv_y;
    logic [31:0]       conv_cbcr;
    logic [31:0]       conv_r_off;
    logic [31:0]       conv_g_off;
    logic [31:0]       conv_b_off;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_r;
    logic [7:0]        pix_g;
    logic [7:0]        pix_b;
    logic [ADDR_W-1:0] pix_idx;
    logic              pix_last;

    modport master (
        input  blk_valid, buf_y, buf_cb, buf_cr, conv_r_off, conv_g_off, conv_b_off, pix_ready,
        output blk_ready, blk_done, buf_rd_en, buf_rd_addr, conv_y, conv_cbcr,
               pix_valid, pix_r, pix_g, pix_b, pix_idx, pix_last
    );

    modport slave (
        output blk_valid, buf_y, buf_cb, buf_cr, conv_r_off, conv_g_off, conv_b_off, pix_ready,
        input  blk_ready, blk_done, buf_rd_en, buf_rd_addr, conv_y, conv_cbcr,
               pix_valid, pix_r, pix_g, pix_b, pix_idx, pix_last
    );

endinterface

// File: rtl/ycc_chan_sat.sv
// One colour channel: Y plus signed 16.16 chroma offset, floored and clamped to 0..255.
module ycc_chan_sat #(
    parameter int unsigned FRAC_W = ycc_ctrl_pkg::FRAC_W
) (
    input  logic [7:0]  y,
    input  logic [31:0] off,
    output logic [7:0]  pix
);
    import ycc_ctrl_pkg::*;

    logic signed [32:0] y_fix;
    logic signed [32:0] sum;
    logic signed [32:0] flr;

    always_comb begin
        y_fix = $signed({1'b0, 32'(y) << FRAC_W});
        sum   = y_fix + $signed({off[31], off});
        // Arithmetic shift floors toward -inf; rounding lives in the converter LUTs.
        flr   = sum >>> FRAC_W;
        pix   = sat_u8(flr);
    end

endmodule

// File: rtl/ycc_rgb_conv_ctrl.sv
// Streams one 8x8 YCbCr block through the shared converters and emits RGB pixels ready/valid.
module ycc_rgb_conv_ctrl #(
    parameter int unsigned BLK_PIX = ycc_ctrl_pkg::BLK_PIX,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned FRAC_W  = ycc_ctrl_pkg::FRAC_W
) (
    input logic                clk,
    input logic                rst,
    ycc_rgb_conv_ctrl_if.master bus
);
    import ycc_ctrl_pkg::*;

    localparam logic [1:0]        S_IDLE  = IDLE;
    localparam logic [1:0]        S_RUN   = RUN;
    localparam logic [1:0]        S_DRAIN = DRAIN;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(BLK_PIX - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
    logic              blk_done_q, blk_done_d;
    logic              s1_vld_q;
    logic              pix_valid_q;
    logic [7:0]        pix_r_q, pix_g_q, pix_b_q;
    logic [7:0]        sat_r, sat_g, sat_b;
    logic              adv;
    logic              rd_fire;
    logic              hs;

    // The whole pipeline moves together; a stalled output freezes every stage behind it.
    assign adv     = !pix_valid_q || bus.pix_ready;
    assign rd_fire = (state_q == S_RUN) && adv;
    assign hs      = pix_valid_q && bus.pix_ready;

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        blk_done_d = 1'b0;
        if (hs) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (bus.blk_valid) begin
                    state_d   = S_RUN;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (adv) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (hs && (out_cnt_q == LAST)) begin
                    blk_done_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            blk_done_q  <= 1'b0;
            s1_vld_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_r_q     <= 8'd0;
            pix_g_q     <= 8'd0;
            pix_b_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            blk_done_q <= blk_done_d;
            if (adv) begin
                s1_vld_q    <= rd_fire;
                pix_valid_q <= s1_vld_q;
                if (s1_vld_q) begin
                    pix_r_q <= sat_r;
                    pix_g_q <= sat_g;
                    pix_b_q <= sat_b;
                end
            end
        end
    end

    ycc_chan_sat #(.FRAC_W(FRAC_W)) u_sat_r (
        .y   (bus.buf_y),
        .off (bus.conv_r_off),
        .pix (sat_r)
    );

    ycc_chan_sat #(.FRAC_W(FRAC_W)) u_sat_g (
        .y   (bus.buf_y),
        .off (bus.conv_g_off),
        .pix (sat_g)
    );

    ycc_chan_sat #(.FRAC_W(FRAC_W)) u_sat_b (
        .y   (bus.buf_y),
        .off (bus.conv_b_off),
        .pix (sat_b)
    );

    assign bus.blk_ready   = (state_q == S_IDLE);
    assign bus.blk_done    = blk_done_q;
    assign bus.buf_rd_en   = rd_fire;
    assign bus.buf_rd_addr = rd_cnt_q;
    assign bus.conv_y      = {24'b0, bus.buf_y};
    assign bus.conv_cbcr   = {16'b0, bus.buf_cb, bus.buf_cr};
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_r       = pix_r_q;
    assign bus.pix_g       = pix_g_q;
    assign bus.pix_b       = pix_b_q;
    assign bus.pix_idx     = out_cnt_q;
    assign bus.pix_last    = (out_cnt_q == LAST);

endmodule

// File: tb/tb_ycc_rgb_conv_ctrl.sv
// Bench for ycc_rgb_conv_ctrl: block buffer and converter models, directed table plus random blocks.
module tb_ycc_rgb_conv_ctrl;
    localparam int unsigned BLK = 64;
    localparam int unsigned AW  = 6;
    localparam int          NV  = 12;
    localparam int MODE_FREE   = 0;
    localparam int MODE_TOGGLE = 1;
    localparam int MODE_RAND   = 2;

    typedef struct {
        logic [7:0]  y;
        logic [31:0] ro;
        logic [31:0] go;
        logic [31:0] bo;
        logic [7:0]  er;
        logic [7:0]  eg;
        logic [7:0]  eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc  = 0;
    int   nchk = 0;
    int   nerr = 0;

    ycc_rgb_conv_ctrl_if #(.ADDR_W(AW)) bus ();

    ycc_rgb_conv_ctrl #(
        .BLK_PIX (BLK),
        .ADDR_W  (AW),
        .FRAC_W  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  ymem  [BLK];
    logic [7:0]  cbmem [BLK];
    logic [7:0]  crmem [BLK];
    logic [31:0] roff  [65536];
    logic [31:0] goff  [65536];
    logic [31:0] boff  [65536];
    logic [31:0] exp_w [BLK];
    logic [31:0] got_q [$];
    int          acc_hist [$];
    int          done_hist [$];
    int          blk_started = 0;
    vec_t        vt [NV];

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b, input logic [AW-1:0] idx,
                                         input logic last);
        return {1'b0, r, g, b, idx, last};
    endfunction

    // Reference: real-valued Y + offset/65536, floored, then clamped to a byte.
    function automatic int ref_chan(input int y, input logic [31:0] off);
        real v;
        v = $floor(real'(y) + real'($signed(off)) / 65536.0);
        if (v < 0.0) return 0;
        if (v > 255.0) return 255;
        return int'(v);
    endfunction

    function automatic logic [31:0] rand_off();
        return 32'($urandom_range(0, 32'h0280_0000)) - 32'h0140_0000;
    endfunction

    // Block buffers: registered read, output held while no read is issued.
    always @(posedge clk) begin
        if (rst) begin
            bus.buf_y  <= 8'd0;
            bus.buf_cb <= 8'd0;
            bus.buf_cr <= 8'd0;
        end else if (bus.buf_rd_en) begin
            bus.buf_y  <= ymem[bus.buf_rd_addr];
            bus.buf_cb <= cbmem[bus.buf_rd_addr];
            bus.buf_cr <= crmem[bus.buf_rd_addr];
        end
    end

    assign bus.conv_r_off = roff[bus.conv_cbcr[15:0]];
    assign bus.conv_g_off = goff[bus.conv_cbcr[15:0]];
    assign bus.conv_b_off = boff[bus.conv_cbcr[15:0]];

    logic [31:0] cur_word;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_word = '0;
    assign cur_word = pack(bus.pix_r, bus.pix_g, bus.pix_b, bus.pix_idx, bus.pix_last);

    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            check("conv_inputs", {bus.conv_y, bus.conv_cbcr},
                  {24'b0, bus.buf_y, 16'b0, bus.buf_cb, bus.buf_cr});
            if (bus.blk_valid && bus.blk_ready) acc_hist.push_back(cyc);
            if (bus.blk_done) done_hist.push_back(cyc);
            if (stall_prev) begin
                check("stall_valid", bus.pix_valid, 1);
                check("stall_hold", cur_word, stall_word);
            end
            if (bus.pix_valid && !bus.pix_ready) check("stall_rd_en", bus.buf_rd_en, 0);
            if (bus.pix_valid && bus.pix_ready) got_q.push_back(cur_word);
            stall_prev <= bus.pix_valid && !bus.pix_ready;
            stall_word <= cur_word;
        end
    end

    task automatic build_exp_model();
        for (int i = 0; i < BLK; i++) begin
            logic [15:0] key = {cbmem[i], crmem[i]};
            exp_w[i] = pack(8'(ref_chan(int'(ymem[i]), roff[key])),
                            8'(ref_chan(int'(ymem[i]), goff[key])),
                            8'(ref_chan(int'(ymem[i]), boff[key])), AW'(i), i == BLK - 1);
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < BLK; i++) begin
            logic [15:0] key;
            ymem[i]  = 8'($urandom);
            cbmem[i] = 8'($urandom);
            crmem[i] = 8'($urandom);
            key = {cbmem[i], crmem[i]};
            roff[key] = rand_off();
            goff[key] = rand_off();
            boff[key] = rand_off();
        end
        build_exp_model();
    endtask

    task automatic load_table();
        for (int i = 0; i < BLK; i++) begin
            vec_t v = vt[i % NV];
            logic [15:0] key;
            ymem[i]  = v.y;
            cbmem[i] = 8'(i);
            crmem[i] = 8'h5a;
            key = {cbmem[i], crmem[i]};
            roff[key] = v.ro;
            goff[key] = v.go;
            boff[key] = v.bo;
            exp_w[i] = pack(v.er, v.eg, v.eb, AW'(i), i == BLK - 1);
        end
    endtask

    task automatic load_neutral();
        for (int i = 0; i < BLK; i++) begin
            logic [15:0] key;
            ymem[i]  = 8'd100;
            cbmem[i] = 8'h80;
            crmem[i] = 8'(i);
            key = {cbmem[i], crmem[i]};
            roff[key] = 32'h0000_8000;
            goff[key] = 32'h0000_8000;
            boff[key] = 32'h0000_8000;
            exp_w[i] = pack(8'd100, 8'd100, 8'd100, AW'(i), i == BLK - 1);
        end
    endtask

    // Runs one block from acceptance to blk_done; always returns at posedge+1.
    task automatic run_block(input int mode, input bit keep_valid, output int acc_c,
                             output int done_c);
        int base_acc  = blk_started;
        int base_done = done_hist.size();
        int k = 0;
        int burst = 0;
        bit burst_done = 1'b0;
        acc_c  = -1;
        done_c = -1;
        got_q.delete();
        blk_started++;
        bus.blk_valid = 1'b1;
        while (acc_hist.size() <= base_acc && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("accept", acc_hist.size() > base_acc, 1);
        if (acc_hist.size() <= base_acc) begin
            bus.blk_valid = 1'b0;
            return;
        end
        acc_c = acc_hist[base_acc];
        if (!keep_valid) bus.blk_valid = 1'b0;
        k = 0;
        while (done_hist.size() <= base_done && k < 3000) begin
            case (mode)
                MODE_TOGGLE: begin
                    if (burst > 0) begin
                        bus.pix_ready = 1'b0;
                        burst--;
                    end else if (!burst_done && bus.pix_valid && bus.pix_idx == 6'd20) begin
                        burst_done = 1'b1;
                        burst = 9;
                        bus.pix_ready = 1'b0;
                    end else begin
                        bus.pix_ready = !bus.pix_ready;
                    end
                end
                MODE_RAND: bus.pix_ready = ($urandom % 4) != 0;
                default:   bus.pix_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            k++;
        end
        bus.pix_ready = 1'b1;
        check("blk_done_seen", done_hist.size() > base_done, 1);
        if (done_hist.size() > base_done) done_c = done_hist[base_done];
        if (!keep_valid) begin
            repeat (4) begin
                @(posedge clk); #1;
            end
        end
        check("blk_done_pulses", done_hist.size(), base_done + 1);
        check("pix_count", got_q.size(), BLK);
        for (int i = 0; i < BLK; i++) begin
            check($sformatf("pix[%0d]", i), (i < got_q.size()) ? got_q[i] : 32'hffff_ffff,
                  exp_w[i]);
        end
    endtask

    int a1, d1, a2, d2, base, k0, dcnt;

    initial begin
        vt[0]  = '{8'd100, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 8'd100, 8'd100, 8'd100};
        vt[1]  = '{8'd200, 32'h005b_6900, 32'h0000_0000, 32'h0000_0000, 8'd255, 8'd200, 8'd200};
        vt[2]  = '{8'd10,  32'h0000_0000, 32'h0000_0000, 32'hffa5_4dd2, 8'd10,  8'd10,  8'd0};
        vt[3]  = '{8'd50,  32'h0000_0000, 32'hffd4_cb1a, 32'h0000_0000, 8'd50,  8'd6,   8'd50};
        vt[4]  = '{8'd0,   32'hffff_0000, 32'hffff_0000, 32'hffff_0000, 8'd0,   8'd0,   8'd0};
        vt[5]  = '{8'd255, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 8'd255, 8'd255, 8'd255};
        vt[6]  = '{8'd255, 32'h0000_0000, 32'h0000_ffff, 32'hffff_0000, 8'd255, 8'd255, 8'd254};
        vt[7]  = '{8'd0,   32'h0000_ffff, 32'h0000_ffff, 32'h0000_ffff, 8'd0,   8'd0,   8'd0};
        vt[8]  = '{8'd128, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 8'd127, 8'd127, 8'd127};
        vt[9]  = '{8'd1,   32'hfffe_8000, 32'h0000_8000, 32'hffff_8000, 8'd0,   8'd1,   8'd0};
        vt[10] = '{8'd254, 32'h0001_ffff, 32'h0000_8000, 32'h0002_0000, 8'd255, 8'd254, 8'd255};
        vt[11] = '{8'd30,  32'h7fff_ffff, 32'h8000_0000, 32'h0000_0000, 8'd255, 8'd0,   8'd30};

        rst = 1'b1;
        bus.blk_valid = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_blk_ready", bus.blk_ready, 1);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_blk_done", bus.blk_done, 0);
        check("rst_rd_en", bus.buf_rd_en, 0);
        check("rst_rd_addr", bus.buf_rd_addr, 0);
        check("rst_pix_rgb", {bus.pix_r, bus.pix_g, bus.pix_b}, 0);
        check("rst_pix_idx", bus.pix_idx, 0);
        check("rst_pix_last", bus.pix_last, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        load_neutral();
        run_block(MODE_FREE, 1'b0, a1, d1);
        check("neutral_latency", d1 - a1, 67);

        load_table();
        run_block(MODE_FREE, 1'b0, a1, d1);
        run_block(MODE_TOGGLE, 1'b0, a1, d1);

        for (int m = 0; m < 3; m++) begin
            load_random();
            run_block(m, 1'b0, a1, d1);
            if (m == MODE_FREE) check("random_latency", d1 - a1, 67);
        end

        load_random();
        run_block(MODE_FREE, 1'b1, a1, d1);
        load_random();
        run_block(MODE_FREE, 1'b0, a2, d2);
        check("b2b_accept_at_done", a2, d1);
        check("accept_count", acc_hist.size(), blk_started);

        load_random();
        got_q.delete();
        base = blk_started;
        blk_started++;
        bus.blk_valid = 1'b1;
        k0 = 0;
        while (acc_hist.size() <= base && k0 < 200) begin
            @(posedge clk); #1;
            k0++;
        end
        bus.blk_valid = 1'b0;
        k0 = 0;
        while (!(bus.pix_valid && bus.pix_idx == 6'd30) && k0 < 200) begin
            @(posedge clk); #1;
            k0++;
        end
        check("reach_idx30", bus.pix_valid && bus.pix_idx == 6'd30, 1);
        dcnt = done_hist.size();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_pix_valid", bus.pix_valid, 0);
        check("midrst_blk_ready", bus.blk_ready, 1);
        check("midrst_rd_en", bus.buf_rd_en, 0);
        check("midrst_pix_idx", bus.pix_idx, 0);
        got_q.delete();
        repeat (80) begin
            @(posedge clk); #1;
        end
        check("midrst_no_pixels", got_q.size(), 0);
        check("midrst_no_done", done_hist.size(), dcnt);

        load_random();
        run_block(MODE_FREE, 1'b0, a1, d1);
        check("post_rst_latency", d1 - a1, 67);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ycc_rgb_conv_ctrl.md
Name: ycc_rgb_conv_ctrl

Overview:
Sequences one 8x8 colour block (4:4:4, 64 pixels) through the LUT-based YCbCr->RGB converters. It reads Y/Cb/Cr from the component block buffers and drives the shared converter inputs. It then adds Y to each returned 16.16 chroma offset, floors and clamps the result to 0..255, and emits a ready/valid RGB pixel stream toward the output/raster writer. It sits between the upsample/block-buffer stage and the pixel writer.

Parameters:
BLK_PIX, 64, pixels per block; must be a power of two.
ADDR_W, 6, buffer address width; equals log2(BLK_PIX).
FRAC_W, 16, fractional bits of the converter offsets.

Ports:
clk  in  1  system clock
rst  in  1  reset
blk_valid  in  1  a complete block is present in the buffers
blk_ready  out  1  controller can accept a block
blk_done  out  1  one-cycle pulse; block fully emitted and buffers may be released
buf_rd_en  out  1  buffer read enable
buf_rd_addr  out  ADDR_W  pixel index read from all three buffers
buf_y  in  8  Y sample, unsigned; valid 1 cycle after a buf_rd_en cycle and held while rd_en is low
buf_cb  in  8  Cb sample, same timing as buf_y
buf_cr  in  8  Cr sample, same timing as buf_y
conv_y  out  32  converter data_a = {24'b0, buf_y}
conv_cbcr  out  32  converter data_b = {16'b0, buf_cb, buf_cr}
conv_r_off  in  32  signed 16.16 R offset; combinational from conv_*
conv_g_off  in  32  signed 16.16 G offset; combinational from conv_*
conv_b_off  in  32  signed 16.16 B offset; combinational from conv_*
pix_valid  out  1  pixel output valid
pix_ready  in  1  downstream accepts pixel
pix_r  out  8  red component
pix_g  out  8  green component
pix_b  out  8  blue component
pix_idx  out  ADDR_W  index of the pixel in the block
pix_last  out  1  pixel is the last of the block (idx == BLK_PIX-1)

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset, including mid-block: state goes to IDLE and all counters clear. Outputs reset to: blk_ready=1 (IDLE value), pix_valid=0, blk_done=0, buf_rd_en=0, buf_rd_addr=0, pix_r/g/b=0, pix_idx=0, pix_last=0. Any in-flight pixels are discarded and blk_done is not issued.
- adv = !pix_valid || pix_ready. Every pipeline register updates only when adv=1.
- FSM states:
  - IDLE: blk_ready=1. On blk_valid, go to RUN and clear rd_cnt and out_cnt.
  - RUN: when adv=1, buf_rd_en=1, buf_rd_addr=rd_cnt, rd_cnt++. After issuing address BLK_PIX-1, go to DRAIN.
  - DRAIN: no reads. When the handshake (pix_valid && pix_ready) occurs with pix_last=1, pulse blk_done for the following cycle and go to IDLE.
- blk_ready=0 outside IDLE. blk_valid outside IDLE is ignored.
- Pipeline:
  - Cycle t: address issued.
  - Cycle t+1: s1_vld set, buffer data on conv_*, offsets return combinationally.
  - Cycle t+2: pix_* registered and pix_valid=1.
  - Latency from address to pixel is 2 cycles. Throughput is 1 pixel/clk with pix_ready held high.
  - With no stalls, blk_done asserts 67 cycles after the blk_valid acceptance edge.
- Stall: while pix_valid && !pix_ready, pix_*, s1_vld, rd_cnt and buf_rd_addr all hold and buf_rd_en=0. No pixel is lost or duplicated.
- Arithmetic per channel:
  - s = ({16'b0, y} << FRAC_W) + off, signed 33-bit.
  - v = s >>> FRAC_W (floor; rounding is already folded into the LUTs).
  - Clamp: v<0 -> 0, v>255 -> 255, otherwise v[7:0].
- pix_idx = out_cnt. out_cnt increments on each handshake. pix_last = (out_cnt == BLK_PIX-1).

Decomposition:
- Package ycc_ctrl_pkg:
  - FRAC_W
  - BLK_PIX
  - state enum {IDLE, RUN, DRAIN}
  - function sat_u8(signed 33-bit) -> 8-bit
- Sub-module ycc_chan_sat (add, shift, clamp for one channel), instantiated 3x.

Test Plan:
- Neutral block: Y=100 for all pixels, all offsets = 32'h00008000, pix_ready=1 -> 64 pixels r=g=b=100, idx 0..63, pix_last only on idx 63, blk_done one cycle after, 67 cycles after accept.
- Saturation high/low: Y=200 with r_off=32'h005b6900 -> pix_r=255. Y=10 with b_off=32'hffa54dd2 -> pix_b=0. Y=50 with g_off=32'hffd4cb1a -> pix_g=6.
- Backpressure: pix_ready toggling 1/0 each cycle, plus a 10-cycle low burst at idx 20 -> pixel stream identical to the no-stall run, no duplicates, pix_* stable while stalled, buf_rd_en=0 during stall.
- Back-to-back blocks: blk_valid held high across two blocks -> second block accepted only in IDLE after blk_done, and its idx restarts at 0.
- Reset mid-block: rst asserted at idx 30 -> next cycle pix_valid=0, blk_ready=1, no blk_done. A new block then runs cleanly from idx 0.
- blk_valid during RUN/DRAIN with blk_ready=0 -> ignored, no counter disturbance.
